// File: rtl/edge_event_arbiter_if.sv
// Handshake/bus bundle for edge_event_arbiter: monitored inputs, masks and the event offer.
// slave is the arbiter side; master is the driver/consumer side.
interface edge_event_arbiter_if;
    logic [7:0] i_in;
    logic [7:0] i_mask;
    logic       i_evt_ready;
    logic       o_evt_valid;
    logic [2:0] o_evt_idx;
    logic       o_evt_rise;
    logic [7:0] o_pending;
    logic       o_overflow;

    modport slave (
        input  i_in,
        input  i_mask,
        input  i_evt_ready,
        output o_evt_valid,
        output o_evt_idx,
        output o_evt_rise,
        output o_pending,
        output o_overflow
    );

    modport master (
        output i_in,
        output i_mask,
        output i_evt_ready,
        input  o_evt_valid,
        input  o_evt_idx,
        input  o_evt_rise,
        input  o_pending,
        input  o_overflow
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Detects masked edges on an 8-bit bus, queues them as pending flags and offers one per cycle.
// Round-robin by default; define EDGE_ARB_FIXED_PRIO_EN for lowest-index-first priority.
module edge_event_arbiter (
    input logic                  i_clk,
    input logic                  i_reset,
    edge_event_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StOffer} state_e;

    state_e     r_state;
    logic [7:0] r_d_last;
    logic [7:0] r_pending;
    logic [7:0] r_dir;
    logic [2:0] r_idx;
    logic       r_rise;
    logic       r_overflow;
`ifndef EDGE_ARB_FIXED_PRIO_EN
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_d;
`endif

    state_e     w_state_d;
    logic [7:0] w_edge;
    logic       w_handshake;
    logic [7:0] w_clr;
    logic [7:0] w_remain;
    logic [7:0] w_pending_d;
    logic [7:0] w_dir_d;
    logic       w_overflow_d;
    logic [2:0] w_base;
    logic [3:0] w_sel;
    logic [2:0] w_idx_d;
    logic       w_rise_d;

    // Returns {found, index} of the first set bit at or after base, wrapping 7->0.
    function automatic logic [3:0] pick_bit(input logic [7:0] req, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] cand;
        res = 4'd0;
        for (int k = 7; k >= 0; k--) begin
            cand = base + 3'(k);
            if (req[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_comb begin
        w_edge       = (bus.i_in ^ r_d_last) & bus.i_mask;
        w_handshake  = (r_state == StOffer) && bus.i_evt_ready;
        w_clr        = w_handshake ? (8'd1 << r_idx) : 8'd0;
        w_remain     = r_pending & ~w_clr;
        // A new edge wins over a same-cycle clear of the same bit.
        w_pending_d  = w_remain | w_edge;
        w_dir_d      = (r_dir & ~w_edge) | (bus.i_in & w_edge);
        w_overflow_d = |(w_edge & w_remain);
`ifdef EDGE_ARB_FIXED_PRIO_EN
        w_base       = 3'd0;
`else
        w_base       = w_handshake ? (r_idx + 3'd1) : r_ptr;
`endif
        w_sel        = pick_bit(w_remain, w_base);

        w_state_d    = r_state;
        w_idx_d      = r_idx;
        w_rise_d     = r_rise;
`ifndef EDGE_ARB_FIXED_PRIO_EN
        w_ptr_d      = r_ptr;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_sel[3]) begin
                    w_state_d = StOffer;
                    w_idx_d   = w_sel[2:0];
                    w_rise_d  = w_dir_d[w_sel[2:0]];
                end
            end
            StOffer: begin
                if (w_handshake) begin
`ifndef EDGE_ARB_FIXED_PRIO_EN
                    w_ptr_d = r_idx + 3'd1;
`endif
                    if (w_sel[3]) begin
                        w_idx_d  = w_sel[2:0];
                        w_rise_d = w_dir_d[w_sel[2:0]];
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // Sampling the bus during reset suppresses a spurious edge on release.
        r_d_last <= bus.i_in;
        if (i_reset) begin
            r_state    <= StIdle;
            r_pending  <= 8'd0;
            r_dir      <= 8'd0;
            r_idx      <= 3'd0;
            r_rise     <= 1'b0;
            r_overflow <= 1'b0;
`ifndef EDGE_ARB_FIXED_PRIO_EN
            r_ptr      <= 3'd0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_pending  <= w_pending_d;
            r_dir      <= w_dir_d;
            r_idx      <= w_idx_d;
            r_rise     <= w_rise_d;
            r_overflow <= w_overflow_d;
`ifndef EDGE_ARB_FIXED_PRIO_EN
            r_ptr      <= w_ptr_d;
`endif
        end
    end

    assign bus.o_evt_valid = (r_state == StOffer);
    assign bus.o_evt_idx   = r_idx;
    assign bus.o_evt_rise  = r_rise;
    assign bus.o_pending   = r_pending;
    assign bus.o_overflow  = r_overflow;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (default round-robin build;
// the fairness section swaps expectations when EDGE_ARB_FIXED_PRIO_EN is defined).
module tb_edge_event_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    edge_event_arbiter_if bus_if ();

    edge_event_arbiter u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_offer(input string tag, input logic v, input logic [2:0] idx,
                               input logic rise);
        check({tag, "_valid"}, {7'd0, bus_if.o_evt_valid}, {7'd0, v});
        if (v) begin
            check({tag, "_idx"}, {5'd0, bus_if.o_evt_idx}, {5'd0, idx});
            check({tag, "_rise"}, {7'd0, bus_if.o_evt_rise}, {7'd0, rise});
        end
    endtask

    task automatic do_reset(input logic [7:0] in_val);
        reset = 1'b1;
        bus_if.i_in = in_val;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus_if.i_in = 8'h00;
        bus_if.i_mask = 8'hFF;
        bus_if.i_evt_ready = 1'b0;

        // Reset state, with the bus deliberately non-zero during reset.
        do_reset(8'h3C);
        reset = 1'b1;
        tick();
        check("rst_valid", {7'd0, bus_if.o_evt_valid}, 8'h00);
        check("rst_idx", {5'd0, bus_if.o_evt_idx}, 8'h00);
        check("rst_rise", {7'd0, bus_if.o_evt_rise}, 8'h00);
        check("rst_pending", bus_if.o_pending, 8'h00);
        check("rst_overflow", {7'd0, bus_if.o_overflow}, 8'h00);
        reset = 1'b0;
        tick();
        check("post_rst_pending", bus_if.o_pending, 8'h00);
        tick();
        check_offer("post_rst", 1'b0, 3'd0, 1'b0);

        // Single rising edge on bit 0, consumer always ready.
        do_reset(8'h00);
        bus_if.i_evt_ready = 1'b1;
        tick();
        bus_if.i_in = 8'h01;
        tick();
        check("single_pending", bus_if.o_pending, 8'h01);
        check_offer("single_early", 1'b0, 3'd0, 1'b0);
        tick();
        check_offer("single_offer", 1'b1, 3'd0, 1'b1);
        tick();
        check_offer("single_done", 1'b0, 3'd0, 1'b0);
        check("single_clear", bus_if.o_pending, 8'h00);

        // Burst 00->A5 from ptr=0: idx 0,2,5,7 back to back.
        do_reset(8'h00);
        bus_if.i_evt_ready = 1'b1;
        tick();
        bus_if.i_in = 8'hA5;
        tick();
        check("burst_pending", bus_if.o_pending, 8'hA5);
        tick();
        check_offer("burst_e0", 1'b1, 3'd0, 1'b1);
        tick();
        check_offer("burst_e1", 1'b1, 3'd2, 1'b1);
        check("burst_pending_e1", bus_if.o_pending, 8'hA4);
        tick();
        check_offer("burst_e2", 1'b1, 3'd5, 1'b1);
        tick();
        check_offer("burst_e3", 1'b1, 3'd7, 1'b1);
        tick();
        check_offer("burst_end", 1'b0, 3'd0, 1'b0);
        check("burst_pending_end", bus_if.o_pending, 8'h00);

        // Backpressure: bit 0 rises then falls while unaccepted.
        do_reset(8'h00);
        bus_if.i_evt_ready = 1'b0;
        tick();
        bus_if.i_in = 8'h01;
        tick();
        check("bp_pending", bus_if.o_pending, 8'h01);
        check("bp_ovf0", {7'd0, bus_if.o_overflow}, 8'h00);
        bus_if.i_in = 8'h00;
        tick();
        check("bp_ovf1", {7'd0, bus_if.o_overflow}, 8'h01);
        check_offer("bp_offer", 1'b1, 3'd0, 1'b0);
        tick();
        check("bp_ovf2", {7'd0, bus_if.o_overflow}, 8'h00);
        check_offer("bp_hold", 1'b1, 3'd0, 1'b0);
        check("bp_pending_hold", bus_if.o_pending, 8'h01);
        bus_if.i_evt_ready = 1'b1;
        tick();
        check_offer("bp_done", 1'b0, 3'd0, 1'b0);
        check("bp_pending_done", bus_if.o_pending, 8'h00);

        // Fairness: ptr=1 after the grant of idx 0, now pending=81.
        bus_if.i_evt_ready = 1'b0;
        bus_if.i_in = 8'h81;
        tick();
        check("fair_pending", bus_if.o_pending, 8'h81);
        tick();
`ifdef EDGE_ARB_FIXED_PRIO_EN
        check_offer("fair_first", 1'b1, 3'd0, 1'b1);
        bus_if.i_evt_ready = 1'b1;
        tick();
        check_offer("fair_second", 1'b1, 3'd7, 1'b1);
`else
        check_offer("fair_first", 1'b1, 3'd7, 1'b1);
        bus_if.i_evt_ready = 1'b1;
        tick();
        check_offer("fair_second", 1'b1, 3'd0, 1'b1);
`endif
        tick();
        check_offer("fair_end", 1'b0, 3'd0, 1'b0);

        // Masked bit 0 produces nothing.
        bus_if.i_mask = 8'hFE;
        bus_if.i_in = 8'h80;
        tick();
        check("mask_pending", bus_if.o_pending, 8'h00);
        tick();
        check_offer("mask_none", 1'b0, 3'd0, 1'b0);

        // Reset during an offer discards it.
        bus_if.i_mask = 8'hFF;
        bus_if.i_evt_ready = 1'b0;
        bus_if.i_in = 8'h88;
        tick();
        check("mr_pending", bus_if.o_pending, 8'h08);
        tick();
        check_offer("mr_offer", 1'b1, 3'd3, 1'b1);
        reset = 1'b1;
        tick();
        check_offer("mr_rst", 1'b0, 3'd0, 1'b0);
        check("mr_rst_pending", bus_if.o_pending, 8'h00);
        reset = 1'b0;
        tick();
        tick();
        check_offer("mr_after", 1'b0, 3'd0, 1'b0);
        check("mr_after_pending", bus_if.o_pending, 8'h00);

        // Edge and handshake on the same bit: set wins, no overflow.
        do_reset(8'h00);
        bus_if.i_evt_ready = 1'b0;
        tick();
        bus_if.i_in = 8'h10;
        tick();
        tick();
        check_offer("sw_offer", 1'b1, 3'd4, 1'b1);
        bus_if.i_evt_ready = 1'b1;
        bus_if.i_in = 8'h00;
        tick();
        check("sw_pending", bus_if.o_pending, 8'h10);
        check("sw_ovf", {7'd0, bus_if.o_overflow}, 8'h00);
        tick();
        check_offer("sw_reoffer", 1'b1, 3'd4, 1'b0);
        tick();
        check_offer("sw_end", 1'b0, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
